// File: rtl/vblank_regen_pkg.sv
// rtl/vblank_regen_pkg.sv - shared types and the aspect helper for vblank_regen
// Contents:
//   vbr_mode_e  - output select modes (11 behaves like pass-through)
//   aspect_sat  - (vis * num) >> shift, clamped to max_val
package vblank_regen_pkg;

  typedef enum logic [1:0] {
    VBR_PASS  = 2'b00,
    VBR_REGEN = 2'b01,
    VBR_AUTO  = 2'b10
  } vbr_mode_e;

  // 32-bit arithmetic is wider than LINE_W + clog2(AR_NUM+1) for any
  // practical frame height, so the product cannot wrap before the clamp.
  function automatic int unsigned aspect_sat(input int unsigned vis,
                                             input int unsigned num,
                                             input int unsigned shift,
                                             input int unsigned max_val);
    int unsigned q;
    q = (vis * num) >> shift;
    return (q > max_val) ? max_val : q;
  endfunction

endpackage

// File: rtl/vblank_regen_if.sv
// rtl/vblank_regen_if.sv - video timing in / regenerated timing out bundle
// Ports (master drives video in, slave is the vblank_regen block):
//   hs_in_n, vs_in, vb_in, mode                     - video timing and select
//   vb_out, ary, total_lines, visible_lines         - regenerated blank and stats
//   locked, frame_strobe, field                     - status
interface vblank_regen_if #(
  parameter int LINE_W = 9,
  parameter int ARY_W  = 8
);
  logic              hs_in_n;
  logic              vs_in;
  logic              vb_in;
  logic [1:0]        mode;
  logic              vb_out;
  logic [ARY_W-1:0]  ary;
  logic [LINE_W-1:0] total_lines;
  logic [LINE_W-1:0] visible_lines;
  logic              locked;
  logic              frame_strobe;
  logic              field;

  modport master (
    output hs_in_n, vs_in, vb_in, mode,
    input  vb_out, ary, total_lines, visible_lines, locked, frame_strobe, field
  );

  modport slave (
    input  hs_in_n, vs_in, vb_in, mode,
    output vb_out, ary, total_lines, visible_lines, locked, frame_strobe, field
  );
endinterface

// File: rtl/vbr_lock_detect.sv
// rtl/vbr_lock_detect.sv - frame-height stability tracker
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   frame_ev_i      - one-cycle frame event
//   line_cnt_i      - height of the frame that is just ending
//   total_lines_i   - height of the frame before it
//   locked_o        - STABLE_FRAMES consecutive heights within +/-1
module vbr_lock_detect #(
  parameter int LINE_W        = 9,
  parameter int STABLE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_ev_i,
  input  logic [LINE_W-1:0] line_cnt_i,
  input  logic [LINE_W-1:0] total_lines_i,
  output logic              locked_o
);
  localparam int SC_W = $clog2(STABLE_FRAMES + 1);

  logic [SC_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic              locked_q, locked_d;
  logic [LINE_W-1:0] diff;
  logic              match;

  always_comb begin
    stable_cnt_d = stable_cnt_q;
    locked_d     = locked_q;
    diff  = (line_cnt_i >= total_lines_i) ? (line_cnt_i - total_lines_i)
                                          : (total_lines_i - line_cnt_i);
    // +/-1 tolerance lets alternating 262/263 interlaced fields stay locked
    match = (diff <= LINE_W'(1));
    if (frame_ev_i) begin
      if (!match) begin
        stable_cnt_d = '0;
      end else if (stable_cnt_q != SC_W'(STABLE_FRAMES)) begin
        stable_cnt_d = stable_cnt_q + 1'b1;
      end
      locked_d = (stable_cnt_d == SC_W'(STABLE_FRAMES));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt_q <= '0;
      locked_q     <= 1'b0;
    end else begin
      stable_cnt_q <= stable_cnt_d;
      locked_q     <= locked_d;
    end
  end

  assign locked_o = locked_q;
endmodule

// File: rtl/vblank_regen.sv
// rtl/vblank_regen.sv - line/frame measurement, vblank regeneration and aspect
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   vif        - vblank_regen_if.slave (video timing in, regenerated blank out)
// Optional: define VBLANK_REGEN_FIELD_EN to build the interlace field tracker;
// otherwise field is tied low.
module vblank_regen
  import vblank_regen_pkg::*;
#(
  parameter int LINE_W        = 9,
  parameter int ARY_W         = 8,
  parameter int TOP_LINE      = 34,
  parameter int BOTTOM_MARGIN = 25,
  parameter int STABLE_FRAMES = 4,
  parameter int AR_NUM        = 9,
  parameter int AR_SHIFT      = 4,
  parameter int ARY_RESET     = 108
) (
  input logic           clk,
  input logic           reset,
  vblank_regen_if.slave vif
);
  localparam int MIN_REGEN = TOP_LINE + BOTTOM_MARGIN;

  logic              hs_q, hs_prev_q;
  logic              vs_q, vs_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
  logic [LINE_W-1:0] vis_cnt_q, vis_cnt_d;
  logic [LINE_W-1:0] vb_start_q, vb_start_d;
  logic [LINE_W-1:0] total_q, total_d;
  logic [LINE_W-1:0] visible_q, visible_d;
  logic [ARY_W-1:0]  ary_q, ary_d;
  logic              regen_q, regen_d;
  logic              strobe_q, strobe_d;
  logic              locked;
  logic              line_ev, frame_ev;
  logic              vb_sel;

  assign line_ev  = hs_q & ~hs_prev_q;
  assign frame_ev = line_ev & ~vs_q & vif.vs_in;

  always_comb begin
    vb_sel = vif.vb_in;
    case (vif.mode)
      VBR_REGEN: vb_sel = regen_q;
      VBR_AUTO:  vb_sel = locked ? regen_q : vif.vb_in;
      default:   vb_sel = vif.vb_in;
    endcase
  end

  always_comb begin
    vs_d       = vs_q;
    line_cnt_d = line_cnt_q;
    vis_cnt_d  = vis_cnt_q;
    vb_start_d = vb_start_q;
    total_d    = total_q;
    visible_d  = visible_q;
    ary_d      = ary_q;
    regen_d    = regen_q;
    strobe_d   = 1'b0;
    if (line_ev) begin
      vs_d = vif.vs_in;
      if (line_cnt_q == vb_start_q)         regen_d = 1'b1;
      if (line_cnt_q == LINE_W'(TOP_LINE))  regen_d = 1'b0;
      if (frame_ev) begin
        total_d    = line_cnt_q;
        visible_d  = vis_cnt_q;
        line_cnt_d = '0;
        vis_cnt_d  = '0;
        strobe_d   = 1'b1;
        ary_d      = ARY_W'(aspect_sat(32'(vis_cnt_q), 32'(AR_NUM), 32'(AR_SHIFT),
                                       32'((1 << ARY_W) - 1)));
        // Short frames park the start at all-ones so the blank never
        // asserts before the top margin has closed it.
        vb_start_d = (line_cnt_q <= LINE_W'(MIN_REGEN)) ? '1
                                                         : line_cnt_q - LINE_W'(BOTTOM_MARGIN);
      end else begin
        if (line_cnt_q != '1)            line_cnt_d = line_cnt_q + 1'b1;
        if (!vb_sel && vis_cnt_q != '1)  vis_cnt_d  = vis_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // hsync idles high; resetting the edge detector high avoids a
      // phantom line event on the first cycle out of reset
      hs_q       <= 1'b1;
      hs_prev_q  <= 1'b1;
      vs_q       <= 1'b0;
      line_cnt_q <= '0;
      vis_cnt_q  <= '0;
      vb_start_q <= '1;
      total_q    <= '0;
      visible_q  <= '0;
      ary_q      <= ARY_W'(ARY_RESET);
      regen_q    <= 1'b1;
      strobe_q   <= 1'b0;
    end else begin
      hs_q       <= vif.hs_in_n;
      hs_prev_q  <= hs_q;
      vs_q       <= vs_d;
      line_cnt_q <= line_cnt_d;
      vis_cnt_q  <= vis_cnt_d;
      vb_start_q <= vb_start_d;
      total_q    <= total_d;
      visible_q  <= visible_d;
      ary_q      <= ary_d;
      regen_q    <= regen_d;
      strobe_q   <= strobe_d;
    end
  end

  vbr_lock_detect #(
    .LINE_W        (LINE_W),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_lock (
    .clk           (clk),
    .reset         (reset),
    .frame_ev_i    (frame_ev),
    .line_cnt_i    (line_cnt_q),
    .total_lines_i (total_q),
    .locked_o      (locked)
  );

`ifdef VBLANK_REGEN_FIELD_EN
  logic field_q, field_d;

  // Odd/even frame heights alternate on interlaced sources
  always_comb begin
    field_d = field_q;
    if (frame_ev && (line_cnt_q[0] != total_q[0])) field_d = ~field_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) field_q <= 1'b0;
    else       field_q <= field_d;
  end

  assign vif.field = field_q;
`else
  assign vif.field = 1'b0;
`endif

  assign vif.vb_out        = vb_sel;
  assign vif.ary           = ary_q;
  assign vif.total_lines   = total_q;
  assign vif.visible_lines = visible_q;
  assign vif.locked        = locked;
  assign vif.frame_strobe  = strobe_q;
endmodule

// File: tb/tb_vblank_regen.sv
// tb/tb_vblank_regen.sv - scoreboard bench for vblank_regen
module tb_vblank_regen;
  localparam int LINE_W  = 9;
  localparam int ARY_W   = 8;
  localparam int TOP     = 34;
  localparam int BM      = 25;
  localparam int SF      = 4;
  localparam int NUM     = 9;
  localparam int SH      = 4;
  localparam int ARY_RST = 108;
  localparam int LMAX    = (1 << LINE_W) - 1;
  localparam int AMAX    = (1 << ARY_W) - 1;

  typedef struct {
    int total;
    int visible;
    int ary;
    int locked;
    int field;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vblank_regen_if #(.LINE_W(LINE_W), .ARY_W(ARY_W)) vif ();

  vblank_regen dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif)
  );

  int   total_cnt = 0;
  int   bad_cnt   = 0;
  exp_t sb[$];
  int   mode_v;

  // reference state, advanced once per line event
  int m_line, m_vis, m_vs, m_vbs, m_regen, m_total, m_visible, m_ary;
  int m_stable, m_locked, m_field;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_line = 0; m_vis = 0; m_vs = 0; m_vbs = LMAX; m_regen = 1;
    m_total = 0; m_visible = 0; m_ary = ARY_RST;
    m_stable = 0; m_locked = 0; m_field = 0;
  endfunction

  function automatic int sel(input int vb);
    if (mode_v == 1) return m_regen;
    if (mode_v == 2) return m_locked ? m_regen : vb;
    return vb;
  endfunction

  task automatic model_step(input int vs, input int vb);
    int   vbo, rn, diff, a;
    exp_t e;
    vbo = sel(vb);
    rn  = m_regen;
    if (m_line == m_vbs) rn = 1;
    if (m_line == TOP)   rn = 0;
    if (m_vs == 0 && vs == 1) begin
      diff = (m_line > m_total) ? m_line - m_total : m_total - m_line;
      if (diff <= 1) m_stable = (m_stable < SF) ? m_stable + 1 : SF;
      else           m_stable = 0;
      m_locked = (m_stable == SF) ? 1 : 0;
`ifdef VBLANK_REGEN_FIELD_EN
      if ((m_line % 2) != (m_total % 2)) m_field = 1 - m_field;
`endif
      m_total   = m_line;
      m_visible = m_vis;
      a         = (m_vis * NUM) >> SH;
      m_ary     = (a > AMAX) ? AMAX : a;
      m_vbs     = (m_line <= TOP + BM) ? LMAX : m_line - BM;
      m_line    = 0;
      m_vis     = 0;
      e.total = m_total; e.visible = m_visible; e.ary = m_ary;
      e.locked = m_locked; e.field = m_field;
      sb.push_back(e);
    end else begin
      if (m_line < LMAX) m_line++;
      if (vbo == 0 && m_vis < LMAX) m_vis++;
    end
    m_vs    = vs;
    m_regen = rn;
  endtask

  // one hsync period of 6 clocks; vb_out is sampled while the line event is live
  task automatic line(input int vs, input int vb);
    @(negedge clk);
    vif.hs_in_n = 1'b0;
    vif.vs_in   = vs[0];
    vif.vb_in   = vb[0];
    @(negedge clk);
    @(negedge clk);
    vif.hs_in_n = 1'b1;
    @(negedge clk);
    check("vb_out", 32'(vif.vb_out), sel(vb));
    model_step(vs, vb);
    repeat (2) @(negedge clk);
  endtask

  // frame-start line plus n further lines; source blank is low on lines vlo..vhi
  task automatic frame(input int n, input int vlo, input int vhi);
    for (int k = 0; k <= n; k++)
      line((k < 3) ? 1 : 0, (k >= vlo && k <= vhi) ? 0 : 1);
  endtask

  task automatic set_mode(input int m);
    mode_v   = m;
    vif.mode = m[1:0];
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ary"},     32'(vif.ary), ARY_RST);
    check({tag, "_locked"},  32'(vif.locked), 0);
    check({tag, "_total"},   32'(vif.total_lines), 0);
    check({tag, "_visible"}, 32'(vif.visible_lines), 0);
    check({tag, "_strobe"},  32'(vif.frame_strobe), 0);
    check({tag, "_field"},   32'(vif.field), 0);
    vif.vb_in = 1'b1;
    #1 check({tag, "_vbpass1"}, 32'(vif.vb_out), 1);
    vif.vb_in = 1'b0;
    #1 check({tag, "_vbpass0"}, 32'(vif.vb_out), 0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && vif.frame_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_spurious_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("total_lines",   32'(vif.total_lines), e.total);
        check("visible_lines", 32'(vif.visible_lines), e.visible);
        check("ary",           32'(vif.ary), e.ary);
        check("locked",        32'(vif.locked), e.locked);
        check("field",         32'(vif.field), e.field);
      end
    end
  end

  initial begin
    vif.hs_in_n = 1'b1;
    vif.vs_in   = 1'b0;
    vif.vb_in   = 1'b0;
    set_mode(2);
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;

    // partial frame, then steady 262-line frames until lock (auto mode)
    repeat (10) line(0, 1);
    repeat (7) frame(262, 20, 256);
    check("locked_after_run", 32'(vif.locked), 1);

    // a 300-line frame breaks lock at the following frame event
    frame(300, 20, 294);
    repeat (2) frame(262, 20, 256);
    check("unlocked_after_300", 32'(vif.locked), 0);

    // forced regeneration
    set_mode(1);
    repeat (2) frame(262, 20, 256);

    // pass-through: 228 visible lines, then saturation on a 520-line frame
    set_mode(0);
    repeat (2) frame(262, 1, 228);
    frame(520, 0, 999);
    frame(262, 20, 256);

    // interlaced-style alternating heights in auto mode
    set_mode(2);
    repeat (4) begin
      frame(262, 20, 256);
      frame(263, 20, 257);
    end
    check("locked_interlace", 32'(vif.locked), 1);

    // reset in the middle of a frame
    repeat (40) line(0, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("midrst");
    model_reset();
    reset = 1'b0;
    repeat (5) line(0, 1);
    repeat (3) frame(262, 20, 256);
    check("no_lock_after_reset", 32'(vif.locked), 0);

    repeat (3) line(0, 1);
    check("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
